// File: rtl/dmem_pkg.sv
// Shared types and constants for the CPU data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RAM_WAIT,
    IO_WAIT,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    RAM,
    IO,
    UNMAPPED
  } region_e;

  localparam logic [15:0] IO_BASE_HI   = 16'hE000;
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  function automatic region_e decode_region(input logic [31:0] addr,
                                            input logic [32:0] ram_bytes);
    if ({1'b0, addr} < ram_bytes) return RAM;
    if (addr[31:16] == IO_BASE_HI) return IO;
    return UNMAPPED;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous RAM, byte-lane write enables, registered read (1 cycle).
module dmem_ram #(
  parameter int unsigned RAM_WORDS = 4096
) (
  input  logic                         clock,
  input  logic                         en_i,
  input  logic                         we_i,
  input  logic [3:0]                   wstrb_i,
  input  logic [$clog2(RAM_WORDS)-1:0] addr_i,
  input  logic [31:0]                  wdata_i,
  output logic [31:0]                  rdata_o
);

  logic [31:0] mem_q [RAM_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clock) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < 4; b++) begin
          if (wstrb_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// CPU data-bus responder: decodes RAM / 64 KB IO window / unmapped, adds RAM wait states.
// `DMEM_IO_TIMEOUT_EN` aborts IO accesses left unacknowledged for 256 cycles.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned RAM_WORDS   = 4096,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_request,
  input  logic [31:0] cpu_address,
  input  logic        cpu_write,
  input  logic [3:0]  cpu_wstrb,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_mem_busy,
  output logic        cpu_valid,
  output logic        io_request,
  output logic [15:0] io_address,
  output logic        io_write,
  output logic [3:0]  io_wstrb,
  output logic [31:0] io_wdata,
  input  logic [31:0] io_rdata,
  input  logic        io_ack,
  output logic        io_timeout
);

  localparam int unsigned AW        = $clog2(RAM_WORDS);
  localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) << 2;

  state_e      state_q;
  logic        busy_q;
  logic        valid_q;
  logic        ram_sel_q;
  logic        write_q;
  logic [3:0]  wait_q;
  logic [31:0] rdata_q;
  logic        io_req_q;
  logic [15:0] io_addr_q;
  logic        io_write_q;
  logic [3:0]  io_wstrb_q;
  logic [31:0] io_wdata_q;
`ifdef DMEM_IO_TIMEOUT_EN
  logic [7:0]  to_cnt_q;
  logic        io_timeout_q;
`endif

  region_e     region;
  logic        accept;
  logic        ram_en;
  logic [31:0] ram_rdata;

  assign region = decode_region(cpu_address, RAM_BYTES);
  assign accept = cpu_request && !busy_q;
  // RAM writes commit on the accept edge itself; reset must not let one through.
  assign ram_en = accept && reset && (region == RAM);

  dmem_ram #(.RAM_WORDS(RAM_WORDS)) u_ram (
    .clock   (clock),
    .en_i    (ram_en),
    .we_i    (cpu_write),
    .wstrb_i (cpu_wstrb),
    .addr_i  (cpu_address[AW+1:2]),
    .wdata_i (cpu_wdata),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      ram_sel_q  <= 1'b0;
      write_q    <= 1'b0;
      wait_q     <= 4'd0;
      rdata_q    <= 32'h0;
      io_req_q   <= 1'b0;
      io_addr_q  <= 16'h0;
      io_write_q <= 1'b0;
      io_wstrb_q <= 4'h0;
      io_wdata_q <= 32'h0;
`ifdef DMEM_IO_TIMEOUT_EN
      to_cnt_q     <= 8'd0;
      io_timeout_q <= 1'b0;
`endif
    end else begin
      valid_q   <= 1'b0;
      ram_sel_q <= 1'b0;
      // RAM read data is only muxed out during DONE; capture it so it persists.
      if (ram_sel_q) rdata_q <= ram_rdata;
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            write_q <= cpu_write;
            case (region)
              RAM: begin
                if (WAIT_STATES == 0) begin
                  state_q   <= DONE;
                  valid_q   <= !cpu_write;
                  ram_sel_q <= !cpu_write;
                end else begin
                  state_q <= RAM_WAIT;
                  busy_q  <= 1'b1;
                  wait_q  <= 4'(WAIT_STATES - 1);
                end
              end
              IO: begin
                state_q    <= IO_WAIT;
                busy_q     <= 1'b1;
                io_req_q   <= 1'b1;
                io_addr_q  <= cpu_address[15:0];
                io_write_q <= cpu_write;
                io_wstrb_q <= cpu_wstrb;
                io_wdata_q <= cpu_wdata;
`ifdef DMEM_IO_TIMEOUT_EN
                to_cnt_q   <= 8'd0;
`endif
              end
              default: begin
                state_q <= DONE;
                valid_q <= !cpu_write;
                if (!cpu_write) rdata_q <= 32'h0;
              end
            endcase
          end else begin
            state_q <= IDLE;
          end
        end
        RAM_WAIT: begin
          if (wait_q == 4'd0) begin
            state_q   <= DONE;
            busy_q    <= 1'b0;
            valid_q   <= !write_q;
            ram_sel_q <= !write_q;
          end else begin
            wait_q <= wait_q - 4'd1;
          end
        end
        IO_WAIT: begin
          if (io_ack) begin
            state_q  <= DONE;
            busy_q   <= 1'b0;
            io_req_q <= 1'b0;
            valid_q  <= !write_q;
            if (!write_q) rdata_q <= io_rdata;
          end
`ifdef DMEM_IO_TIMEOUT_EN
          else if (to_cnt_q == 8'hFF) begin
            state_q      <= DONE;
            busy_q       <= 1'b0;
            io_req_q     <= 1'b0;
            io_timeout_q <= 1'b1;
            valid_q      <= !write_q;
            if (!write_q) rdata_q <= TIMEOUT_DATA;
          end else begin
            to_cnt_q <= to_cnt_q + 8'd1;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cpu_rdata    = ram_sel_q ? ram_rdata : rdata_q;
  assign cpu_mem_busy = busy_q;
  assign cpu_valid    = valid_q;
  assign io_request   = io_req_q;
  assign io_address   = io_addr_q;
  assign io_write     = io_write_q;
  assign io_wstrb     = io_wstrb_q;
  assign io_wdata     = io_wdata_q;
`ifdef DMEM_IO_TIMEOUT_EN
  assign io_timeout   = io_timeout_q;
`else
  assign io_timeout   = 1'b0;
`endif

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Responder end of the CPU data bus. It accepts `cpu_request` transactions, decodes the address into on-chip RAM, a 64 KB peripheral window or unmapped space, and inserts configurable wait states. It returns read data with a one-cycle `cpu_valid` pulse and holds `cpu_mem_busy` while a transaction is outstanding. It sits between the CPU data port and the RAM/peripheral fabric.

## Interface
- `RAM_WORDS`, default 4096: RAM depth in 32-bit words (power of two); RAM spans 0x0000_0000 .. RAM_WORDS*4-1.
- `WAIT_STATES`, default 0: extra cycles inserted on every RAM access (0..15).
- `clock`  in  1  sole clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `cpu_request`  in  1  transaction request.
- `cpu_address`  in  32  byte address; bits [1:0] ignored.
- `cpu_write`  in  1  1 = write, 0 = read.
- `cpu_wstrb`  in  4  byte enables, bit n = byte lane n.
- `cpu_wdata`  in  32  write data.
- `cpu_rdata`  out  32  read data, valid when `cpu_valid`=1.
- `cpu_mem_busy`  out  1  transaction outstanding, not completing this cycle.
- `cpu_valid`  out  1  one-cycle read-completion pulse.
- `io_request`  out  1  peripheral access, held until `io_ack`.
- `io_address`  out  16  `cpu_address[15:0]`.
- `io_write`  out  1  peripheral write.
- `io_wstrb`  out  4  peripheral byte enables.
- `io_wdata`  out  32  peripheral write data.
- `io_rdata`  in  32  peripheral read data, sampled with `io_ack`.
- `io_ack`  in  1  peripheral completion.
- `io_timeout`  out  1  sticky peripheral-timeout flag (see Configuration).

## Operation
- **Accept:** a request is accepted at a rising edge where `cpu_request`=1 and `cpu_mem_busy`=0. Address, write, wstrb and wdata are registered at that edge.
- **Decode:**
  - RAM when `cpu_address` < RAM_WORDS*4.
  - IO when `cpu_address[31:16]`=16'hE000.
  - Otherwise unmapped.
- **FSM states:** IDLE, RAM_WAIT, IO_WAIT, DONE.
  - IDLE/DONE plus accept → RAM_WAIT (RAM), IO_WAIT (IO) or DONE (unmapped).
  - IDLE/DONE with no accept → IDLE.
  - RAM_WAIT → DONE after WAIT_STATES cycles; with WAIT_STATES=0 it takes 0 extra cycles, so the next state is DONE directly.
  - IO_WAIT → DONE on the edge where `io_ack`=1.
- **RAM writes:** commit at the accept edge. Only lanes with wstrb=1 change.
- **RAM reads:** sample the RAM so that data is presented in DONE.
- **Unmapped accesses:** reads return 0x0000_0000; writes are dropped.
- **DONE:** `cpu_valid`=1 for reads only. `cpu_mem_busy`=0, so a new request may be accepted in the DONE cycle (back-to-back, one access per cycle at WAIT_STATES=0).
- `cpu_rdata` holds its last read value between pulses.
- `cpu_mem_busy`=1 in RAM_WAIT and IO_WAIT, 0 in IDLE and DONE.
- `io_request` rises the cycle after accept and stays 1 through the ack edge. `io_*` outputs are stable while it is 1.
- **Reset:** reset mid-transaction drops the transaction. FSM goes to IDLE, no `cpu_valid` is issued, and `io_request` is 0 the next cycle. Peripheral writes already acked are not undone.

## Timing
- **Reset values:** `cpu_rdata`=0, `cpu_mem_busy`=0, `cpu_valid`=0, `io_request`=0, `io_address`=0, `io_write`=0, `io_wstrb`=0, `io_wdata`=0, `io_timeout`=0.
- **RAM read latency:** accepted in cycle N, `cpu_valid` in cycle N+1+WAIT_STATES; busy is high in cycles N+1 .. N+WAIT_STATES.
- **IO read latency:** `io_ack` sampled in cycle M, `cpu_valid` in cycle M+1.
- **Unmapped:** completes in cycle N+1.
- `io_ack` outside IO_WAIT is ignored.

## Configuration
- `DMEM_IO_TIMEOUT_EN` defined:
  - An 8-bit counter runs in IO_WAIT.
  - After 256 cycles without `io_ack`, `io_request` drops and the FSM moves to DONE.
  - Reads return 0xDEAD_BEEF.
  - `io_timeout` is set and stays set until reset.
  - A late `io_ack` is ignored.
- `DMEM_IO_TIMEOUT_EN` undefined: IO_WAIT waits indefinitely, and `io_timeout` is tied to 0.

## Structure
- Package `dmem_pkg` holds:
  - the FSM state enum;
  - IO_BASE_HI = 16'hE000;
  - TIMEOUT_DATA = 32'hDEAD_BEEF;
  - the region-decode enum {RAM, IO, UNMAPPED}.
- Sub-module `dmem_ram`: single-port synchronous RAM with byte-lane write enables and one-cycle read latency, parameterised by RAM_WORDS.

## Test plan
- **RAM write then read:** write 0x1234_5678 to 0x100, then read 0x100 → `cpu_valid` in cycle N+1 with 0x1234_5678, busy never high (WAIT_STATES=0).
- **Byte strobes:** write 0xFFFF_FFFF to 0x40, then write 0x0000_00AA with wstrb=4'b0001, then read → 0xFFFF_FFAA.
- **Wait states (WAIT_STATES=3):** read accepted in cycle N → busy high in cycles N+1..N+3, valid in N+4; a request held high is accepted in N+4.
- **IO read:** read 0xE000_0010 with `io_ack` after 5 cycles and `io_rdata`=0xCAFE_0001 → `io_address`=0x0010 is held, valid one cycle after ack with 0xCAFE_0001.
- **Unmapped read and reset:** read 0x8000_0000 → 0x0000_0000 in N+1. Reset asserted during IO_WAIT → no `cpu_valid`, `io_request`=0 the next cycle.
- **Timeout (with `DMEM_IO_TIMEOUT_EN`):** IO read with no ack → valid after 256 cycles with 0xDEAD_BEEF, `io_timeout`=1 until reset.
